router_fsm: RTL and testbench
=============================

# router_fsm

Packet-flow controller for the 1x3 router. Sequences each packet from the single input port into one of three output FIFOs: decodes the header address, waits for the target FIFO to drain, and generates the load/full/parity strobes that drive the register block and the synchronizer. Aborts a packet when the target port's soft reset fires. Sits between the input interface and the router synchronizer/register blocks.

## Interface
- No parameters. Address encoding is fixed: 2'b00/01/10 select port 0/1/2; 2'b11 is invalid.
- clock  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- pkt_valid  in  1  source drives packet bytes; high from header through last payload byte
- data_in  in  2  header address bits, sampled in DECODE_ADDRESS
- fifo_full  in  1  full flag of the currently addressed FIFO, from the synchronizer
- fifo_empty_0/1/2  in  1 each  per-port FIFO empty flags
- soft_reset_0/1/2  in  1 each  per-port timeout resets, from the synchronizer
- parity_done  in  1  register block has captured the parity byte
- low_pkt_valid  in  1  register block saw pkt_valid fall while the FIFO was full
- busy  out  1  source must hold data_in stable
- detect_add  out  1  header decode strobe; synchronizer latches the address
- lfd_state  out  1  load-first-data (header write) state
- ld_state  out  1  payload load state
- laf_state  out  1  load-after-full state
- full_state  out  1  FIFO-full stall state
- write_enb_reg  out  1  FIFO write qualifier to the synchronizer
- rst_int_reg  out  1  clears the internal parity register

## Operation
- Moore FSM. All outputs decode combinationally from the state register. addr_q (2 bits) is captured from data_in on every DECODE_ADDRESS cycle.
- DECODE_ADDRESS (reset state): detect_add=1. Transitions:
  - pkt_valid && data_in!=3 && fifo_empty_[data_in] -> LOAD_FIRST_DATA
  - pkt_valid && data_in!=3 && !fifo_empty_[data_in] -> WAIT_TILL_EMPTY
  - pkt_valid && data_in==3 -> DROP_PACKET
  - otherwise stay.
- WAIT_TILL_EMPTY: busy=1. Goes to LOAD_FIRST_DATA when fifo_empty_[addr_q]=1.
- LOAD_FIRST_DATA: lfd_state=1, busy=1, write_enb_reg=1. Goes to LOAD_DATA unconditionally.
- LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0. Priority order:
  - fifo_full -> FIFO_FULL_STATE
  - else !pkt_valid -> LOAD_PARITY
  - else stay.
- FIFO_FULL_STATE: full_state=1, busy=1, write_enb_reg=0. Goes to LOAD_AFTER_FULL when !fifo_full.
- LOAD_AFTER_FULL: laf_state=1, busy=1, write_enb_reg=1. Priority order:
  - parity_done -> DECODE_ADDRESS
  - else low_pkt_valid -> LOAD_PARITY
  - else LOAD_DATA.
- LOAD_PARITY: busy=1, write_enb_reg=1. Goes to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: rst_int_reg=1, busy=1. Goes to FIFO_FULL_STATE if fifo_full, else DECODE_ADDRESS.
- DROP_PACKET: all outputs 0, busy=0. Discards bytes. Returns to DECODE_ADDRESS when pkt_valid=0.
- Soft-reset abort: in any state other than DECODE_ADDRESS and DROP_PACKET, soft_reset_[addr_q]=1 forces DECODE_ADDRESS next cycle. This has priority over all other transitions. Soft resets of non-addressed ports are ignored.
- Outputs not listed for a state are 0.

## Timing
- One state transition per clock. No multi-cycle states.
- Reset: state=DECODE_ADDRESS, addr_q=0. So detect_add=1 and every other output is 0 in the cycle after resetn is sampled low.
- Reset mid-packet: state returns to DECODE_ADDRESS on the next edge regardless of state. No pending write survives.
- Header byte written 1 cycle after the header is presented with an empty FIFO (LOAD_FIRST_DATA).
- busy asserts combinationally with state entry. The source must treat busy as valid in the same cycle.
- Simultaneous events:
  - fifo_full and !pkt_valid in LOAD_DATA: FIFO_FULL_STATE wins.
  - soft_reset and fifo_full: abort wins.

## Structure
- Shared package router_pkg holds:
  - state enum: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY, DROP_PACKET
  - port address constants PORT0=2'b00, PORT1=2'b01, PORT2=2'b10, PORT_INVALID=2'b11.
- Single flat module, no sub-module. It consists of a state register, a next-state block and an output decode block.

## Test plan
- Reset, then pkt_valid=1, data_in=01, fifo_empty_1=1 -> LOAD_FIRST_DATA next cycle (lfd_state=1, busy=1), then LOAD_DATA (ld_state=1, busy=0). Drop pkt_valid -> LOAD_PARITY -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS (detect_add=1).
- data_in=10, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY with busy=1 for 5 cycles. fifo_empty_2 rises -> LOAD_FIRST_DATA next cycle.
- fifo_full=1 during LOAD_DATA -> full_state=1, write_enb_reg=0. fifo_full falls with low_pkt_valid=1 -> LOAD_AFTER_FULL -> LOAD_PARITY. Repeat with parity_done=1 -> DECODE_ADDRESS directly.
- data_in=11 with pkt_valid for 4 cycles -> DROP_PACKET, all strobes 0. pkt_valid falls -> DECODE_ADDRESS.
- soft_reset_0 pulses while in WAIT_TILL_EMPTY for port 0 -> DECODE_ADDRESS next cycle. soft_reset_1 pulsing during a port-0 packet -> no effect.
- resetn low during LOAD_DATA -> DECODE_ADDRESS next cycle, write_enb_reg=0, busy=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and address constants for the 1x3 router blocks.
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY,
    DROP_PACKET
  } state_e;

  localparam logic [1:0] PORT0        = 2'b00;
  localparam logic [1:0] PORT1        = 2'b01;
  localparam logic [1:0] PORT2        = 2'b10;
  localparam logic [1:0] PORT_INVALID = 2'b11;

endpackage

// File: rtl/router_fsm.sv
// Packet-flow controller: steers each packet from the input port into one of
// three output FIFOs and generates the load/full/parity strobes.
import router_pkg::*;

module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  state_e     state_q, state_d;
  logic [1:0] addr_q;
  logic       abort;

  function automatic logic port_sel(input logic [2:0] flags, input logic [1:0] addr);
    case (addr)
      PORT0:   port_sel = flags[0];
      PORT1:   port_sel = flags[1];
      PORT2:   port_sel = flags[2];
      default: port_sel = 1'b0;
    endcase
  endfunction

  // Only the addressed port's soft reset can abort, and only while a packet is in flight.
  assign abort = port_sel({soft_reset_2, soft_reset_1, soft_reset_0}, addr_q) &&
                 (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= PORT0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE_ADDRESS) addr_q <= data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS:
        if (pkt_valid) begin
          if (data_in == PORT_INVALID)
            state_d = DROP_PACKET;
          else if (port_sel({fifo_empty_2, fifo_empty_1, fifo_empty_0}, data_in))
            state_d = LOAD_FIRST_DATA;
          else
            state_d = WAIT_TILL_EMPTY;
        end
      WAIT_TILL_EMPTY:
        if (port_sel({fifo_empty_2, fifo_empty_1, fifo_empty_0}, addr_q))
          state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:
        if (!pkt_valid) state_d = DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase
    if (abort) state_d = DECODE_ADDRESS;
  end

  always_comb begin
    busy          = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    case (state_q)
      DECODE_ADDRESS:     detect_add = 1'b1;
      WAIT_TILL_EMPTY:    busy = 1'b1;
      LOAD_FIRST_DATA:    begin lfd_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
      LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
      LOAD_PARITY:        begin busy = 1'b1; write_enb_reg = 1'b1; end
      CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: the driver queues the expected
// output vector for each cycle, the monitor pops and compares at negedge.
module tb_router_fsm;

  logic clock = 1'b0;
  logic resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic soft_reset_0, soft_reset_1, soft_reset_2;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg)
  );

  // Output vector order: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
  localparam logic [7:0] E_DA   = 8'b0100_0000;
  localparam logic [7:0] E_LFD  = 8'b1010_0010;
  localparam logic [7:0] E_LD   = 8'b0001_0010;
  localparam logic [7:0] E_FULL = 8'b1000_0100;
  localparam logic [7:0] E_LAF  = 8'b1000_1010;
  localparam logic [7:0] E_LP   = 8'b1000_0010;
  localparam logic [7:0] E_CPE  = 8'b1000_0001;
  localparam logic [7:0] E_WTE  = 8'b1000_0000;
  localparam logic [7:0] E_DROP = 8'b0000_0000;

  typedef struct {
    logic [7:0] exp;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL step%0d outputs got %b expected %b", e.id, act, e.exp);
      end
    end
  end

  // exp is the output vector of the state the DUT is in during this cycle;
  // the inputs decide the state after the coming edge.
  task automatic step(input logic rn, input logic pv, input logic [1:0] din, input logic full,
                      input logic [2:0] emp, input logic [2:0] sr, input logic pd,
                      input logic lpv, input logic [7:0] exp);
    exp_t e;
    resetn = rn; pkt_valid = pv; data_in = din; fifo_full = full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done = pd; low_pkt_valid = lpv;
    e.exp = exp; e.id = step_id;
    exp_q.push_back(e);
    step_id++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    @(posedge clock);
    #1;
    //   rn pv din full emp     sr      pd lpv exp
    step(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);   // reset state
    // Normal packet to port 1
    step(1, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_DA);
    step(1, 1, 2'd0, 0, 3'b010, 3'b000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 0, 3'b010, 3'b000, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, E_LP);
    step(1, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, E_CPE);
    step(1, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, E_DA);
    // Port 2 busy for 5 cycles, then full stall with low_pkt_valid exit
    step(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, E_DA);
    for (int i = 0; i < 4; i++)
      step(1, 1, 2'd0, 0, 3'b011, 3'b000, 0, 0, E_WTE);
    step(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_WTE);
    step(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, E_LD);
    step(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, E_FULL);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1, E_FULL);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1, E_LAF);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_LP);
    step(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, E_CPE);  // full at parity check
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_FULL);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 1, 0, E_LAF);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    // Port 0: full and pkt_valid low together, then parity_done exit
    step(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    step(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_LFD);
    step(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_FULL);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 1, 1, E_LAF);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    // Invalid address drop
    step(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, E_DA);
    for (int i = 0; i < 3; i++)
      step(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, E_DROP);
    step(1, 0, 2'd0, 0, 3'b111, 3'b111, 0, 0, E_DROP);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    // Soft resets: port 1 ignored, port 0 aborts the wait
    step(1, 1, 2'd0, 0, 3'b110, 3'b000, 0, 0, E_DA);
    step(1, 1, 2'd0, 0, 3'b110, 3'b010, 0, 0, E_WTE);
    step(1, 1, 2'd0, 0, 3'b110, 3'b001, 0, 0, E_WTE);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    // Abort beats fifo_full in LOAD_DATA
    step(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    step(1, 1, 2'd0, 0, 3'b111, 3'b010, 0, 0, E_LFD);
    step(1, 1, 2'd0, 1, 3'b111, 3'b001, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    // Reset in the middle of LOAD_DATA
    step(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, E_DA);
    step(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_LFD);
    step(0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, E_DA);
    repeat (2) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
